bin_to_bcd_seq: RTL and testbench

Sequential shift-and-add-3 (double-dabble) converter from an unsigned binary word to packed BCD digits.
Sits directly upstream of the single-digit BCD adder: produces the BCD operand digits that the adder consumes (A/B, one nibble per digit).
Start/done handshake with a registered, held result.
One conversion takes BIN_W shift cycles.

---
 rtl/bin_to_bcd_seq.sv | 110 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: unsigned BIN_W-bit binary to DIGITS packed BCD digits.
// One conversion takes BIN_W shift cycles; the result and overflow flag are held between completions.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [BIN_W-1:0]      BIN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  OVF,
    output logic                  state_dbg
);

    // Handshake: START is taken on any rising edge where the converter is idle
    // (BUSY=0, including the DONE cycle); START while BUSY is dropped, never queued.
    // DONE pulses for exactly one cycle when BCD/OVF take a new result.

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [BIN_W-1:0]   shreg;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   scratch_nx;
    logic               ovf_acc;
    logic               ovf_nx;
    logic               last;

    // Add-3 correction per digit; a 4-bit add, so nothing carries between digits.
    always_comb begin
        adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
    end

    // The bit leaving the top digit is worth 10^DIGITS, so dropping it leaves the value mod 10^DIGITS.
    assign scratch_nx = {adj[BCD_W-2:0], shreg[BIN_W-1]};
    assign ovf_nx     = ovf_acc | adj[BCD_W-1];
    assign last       = (cnt == CNT_W'(1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (START) state_nx = SHIFT;
            SHIFT:   if (last)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        BUSY      = (state == SHIFT);
        state_dbg = state;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt     <= '0;
            shreg   <= '0;
            scratch <= '0;
            ovf_acc <= 1'b0;
            BCD     <= '0;
            OVF     <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (state == IDLE) begin
                if (START) begin
                    shreg   <= BIN;
                    scratch <= '0;
                    ovf_acc <= 1'b0;
                    cnt     <= CNT_W'(BIN_W);
                end
            end else begin
                scratch <= scratch_nx;
                shreg   <= {shreg[BIN_W-2:0], 1'b0};
                ovf_acc <= ovf_nx;
                cnt     <= cnt - CNT_W'(1);
                if (last) begin
                    BCD  <= scratch_nx;
                    OVF  <= ovf_nx;
                    DONE <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: vector table plus hand sequences for back-to-back, ignored START,
// mid-conversion reset and a two-digit overflow instance.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic        ovf;
    logic        st;

    logic        start2;
    logic [7:0]  bin2;
    logic        busy2;
    logic        done2;
    logic [7:0]  bcd2;
    logic        ovf2;
    logic        st2;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [12:0] exp_q[$];

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
    } vec_t;

    vec_t vecs[8];

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut (
        .CLK(clk), .RESET(rst), .START(start), .BIN(bin),
        .BUSY(busy), .DONE(done), .BCD(bcd), .OVF(ovf), .state_dbg(st)
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut2 (
        .CLK(clk), .RESET(rst), .START(start2), .BIN(bin2),
        .BUSY(busy2), .DONE(done2), .BCD(bcd2), .OVF(ovf2), .state_dbg(st2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] bcd_model(input int v);
        bcd_model = {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Drive a request at the current point (just after a falling edge) and record its expected result.
    task automatic start_conv(input logic [7:0] b, input logic [11:0] e);
        start = 1'b1;
        bin   = b;
        exp_q.push_back({1'b0, e});
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_done(input bit hold_en, input logic [11:0] hold_val,
                             output int busy_n, output int cyc);
        bit seen;
        logic [12:0] e;
        seen   = 1'b0;
        busy_n = 0;
        cyc    = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1'b1;
            end else if (busy) begin
                busy_n++;
                if (hold_en) check("bcd_hold", 32'(bcd), 32'(hold_val));
            end
        end
        if (!seen) begin
            check("done_timeout", 32'(0), 32'(1));
        end else if (exp_q.size() == 0) begin
            check("spurious_done", 32'(1), 32'(0));
        end else begin
            e = exp_q.pop_front();
            check("result", 32'({ovf, bcd}), 32'(e));
            for (int d = 0; d < 3; d++) begin
                check("digit_legal", 32'(bcd[4*d +: 4] <= 4'd9), 32'(1));
            end
        end
    endtask

    task automatic idle_check(input int n);
        repeat (n) begin
            @(negedge clk);
            check("no_done", 32'(done), 32'(0));
        end
    endtask

    task automatic conv2(input logic [7:0] b, input logic [8:0] e);
        int cyc;
        start2 = 1'b1;
        bin2   = b;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        cyc    = 0;
        while (!done2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!done2) check("done2_timeout", 32'(0), 32'(1));
        else        check("result2", 32'({ovf2, bcd2}), 32'(e));
    endtask

    initial begin
        int bn;
        int cyc;
        int v;

        vecs[0] = '{8'd0,   12'h000};
        vecs[1] = '{8'd255, 12'h255};
        vecs[2] = '{8'd99,  12'h099};
        vecs[3] = '{8'd100, 12'h100};
        vecs[4] = '{8'd1,   12'h001};
        vecs[5] = '{8'd128, 12'h128};
        vecs[6] = '{8'd9,   12'h009};
        vecs[7] = '{8'd10,  12'h010};

        rst    = 1'b1;
        start  = 1'b0;
        bin    = '0;
        start2 = 1'b0;
        bin2   = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_bcd",  32'(bcd),  32'(0));
        check("rst_ovf",  32'(ovf),  32'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            start_conv(vecs[i].bin, vecs[i].bcd);
            wait_done(1'b0, '0, bn, cyc);
            check("busy_cycles", 32'(bn), 32'(8));
            check("latency", 32'(cyc), 32'(9));
            idle_check(1);
        end

        for (int i = 0; i < 6; i++) begin
            v = int'($urandom_range(0, 255));
            start_conv(8'(v), bcd_model(v));
            wait_done(1'b0, '0, bn, cyc);
            idle_check(1);
        end

        // Back-to-back: second request lands in the DONE cycle of the first.
        start_conv(8'd37, 12'h037);
        wait_done(1'b0, '0, bn, cyc);
        start_conv(8'd200, 12'h200);
        wait_done(1'b1, 12'h037, bn, cyc);
        check("b2b_busy", 32'(bn), 32'(8));
        check("b2b_latency", 32'(cyc), 32'(9));
        idle_check(1);

        // START pulse while busy must be dropped.
        start_conv(8'd142, 12'h142);
        repeat (3) @(negedge clk);
        start = 1'b1;
        bin   = 8'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, '0, bn, cyc);
        idle_check(12);

        // Reset four cycles into a conversion aborts it without a DONE.
        start_conv(8'd77, 12'h077);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_bcd",  32'(bcd),  32'(0));
        check("abort_ovf",  32'(ovf),  32'(0));
        check("abort_done", 32'(done), 32'(0));
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        idle_check(12);
        start_conv(8'd77, 12'h077);
        wait_done(1'b0, '0, bn, cyc);
        idle_check(1);

        // Two-digit instance: 255 wraps to 55 with overflow, then a clean conversion clears it.
        conv2(8'd255, 9'h155);
        conv2(8'd42,  9'h042);

        check("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
